// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, the packed complex type
// and the saturation/rounding constants used by the butterfly pipeline.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 15;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam int ROUND_BIAS = 1 << (FRAC_W - 1);

endpackage

// File: rtl/complex_mult.sv
// Complex multiply B*W: registered partial products, then combinational
// round-half-up, arithmetic shift by FRAC_W and saturation to DATA_W bits.
module complex_mult
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int FRAC_W = fft_pkg::FRAC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [2*DATA_W-1:0]        b_in,
  input  logic [2*DATA_W-1:0]        w_in,
  output logic signed [DATA_W-1:0]   p_re,
  output logic signed [DATA_W-1:0]   p_im
);

  localparam int PW = 2*DATA_W + 2;
  localparam int MW = 2*DATA_W;
  localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC_W - 1);
  localparam logic signed [PW-1:0] SMAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] w_br, w_bi, w_wr, w_wi;
  logic signed [MW-1:0]     r_brwr, r_biwi, r_brwi, r_biwr;
  logic signed [PW-1:0]     w_re_full, w_im_full, w_re_shr, w_im_shr;

  assign w_br = b_in[2*DATA_W-1:DATA_W];
  assign w_bi = b_in[DATA_W-1:0];
  assign w_wr = w_in[2*DATA_W-1:DATA_W];
  assign w_wi = w_in[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_brwr <= '0;
      r_biwi <= '0;
      r_brwi <= '0;
      r_biwr <= '0;
    end else if (in_valid) begin
      r_brwr <= MW'(w_br) * MW'(w_wr);
      r_biwi <= MW'(w_bi) * MW'(w_wi);
      r_brwi <= MW'(w_br) * MW'(w_wi);
      r_biwr <= MW'(w_bi) * MW'(w_wr);
    end
  end

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SMAX)      return SMAX[DATA_W-1:0];
    else if (v < SMIN) return SMIN[DATA_W-1:0];
    else               return v[DATA_W-1:0];
  endfunction

  // Two guard bits above the exact product sum keep the rounding add overflow-free.
  assign w_re_full = PW'(r_brwr) - PW'(r_biwi) + RND;
  assign w_im_full = PW'(r_brwi) + PW'(r_biwr) + RND;
  assign w_re_shr  = w_re_full >>> FRAC_W;
  assign w_im_shr  = w_im_full >>> FRAC_W;

  assign p_re = sat(w_re_shr);
  assign p_im = sat(w_im_shr);

endmodule

// File: rtl/butterfly_unit.sv
// Radix-2 DIT butterfly: a_out = A + W*B, b_out = A - W*B, two-cycle
// pipeline with saturating add/sub and no output scaling.
module butterfly_unit
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int FRAC_W = fft_pkg::FRAC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] a_in,
  input  logic [2*DATA_W-1:0] b_in,
  input  logic [2*DATA_W-1:0] w_in,
  output logic                out_valid,
  output logic [2*DATA_W-1:0] a_out,
  output logic [2*DATA_W-1:0] b_out
);

  logic [2*DATA_W-1:0]      r_a;
  logic                     r_v1, r_v2;
  logic [2*DATA_W-1:0]      r_a_out, r_b_out;
  logic signed [DATA_W-1:0] w_p_re, w_p_im;
  logic signed [DATA_W-1:0] w_a_re, w_a_im;

  complex_mult #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_cmul (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .b_in     (b_in),
    .w_in     (w_in),
    .p_re     (w_p_re),
    .p_im     (w_p_im)
  );

  function automatic logic [DATA_W-1:0] addsat(input logic signed [DATA_W-1:0] x,
                                               input logic signed [DATA_W-1:0] y,
                                               input logic sub);
    logic [DATA_W:0] s;
    s = sub ? ({x[DATA_W-1], x} - {y[DATA_W-1], y})
            : ({x[DATA_W-1], x} + {y[DATA_W-1], y});
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction

  // Stage 1: A travels alongside the partial products held inside complex_mult.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) r_a <= a_in;
    end
  end

  assign w_a_re = r_a[2*DATA_W-1:DATA_W];
  assign w_a_im = r_a[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_a_out <= '0;
      r_b_out <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_a_out <= {addsat(w_a_re, w_p_re, 1'b0), addsat(w_a_im, w_p_im, 1'b0)};
        r_b_out <= {addsat(w_a_re, w_p_re, 1'b1), addsat(w_a_im, w_p_im, 1'b1)};
      end
    end
  end

  assign out_valid = r_v2;
  assign a_out     = r_a_out;
  assign b_out     = r_b_out;

endmodule

// File: tb/tb_butterfly_unit.sv
// Directed bench for butterfly_unit with a cycle-stamped scoreboard queue.
module tb_butterfly_unit;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, w_in = '0;
  logic        out_valid;
  logic [31:0] a_out, b_out;

  always #5 clk = ~clk;

  butterfly_unit #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .w_in(w_in),
    .out_valid(out_valid), .a_out(a_out), .b_out(b_out)
  );

  typedef struct {
    int    due;
    cplx_t a;
    cplx_t b;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  logic  rst_q = 1'b1;
  cplx_t last_a = '0, last_b = '0;
  bit    mon_en = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  // Reference arithmetic: floor division instead of shifting.
  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint rnd_scale(input longint p);
    longint x;
    x = p + 16384;
    if (x >= 0) return sat16(x / 32768);
    return sat16(-((-x + 32767) / 32768));
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                       output cplx_t ea, output cplx_t eb);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
    pr = rnd_scale(br*wr - bi*wi);
    pi = rnd_scale(br*wi + bi*wr);
    ea.re = 16'(sat16(ar + pr)); ea.im = 16'(sat16(ai + pi));
    eb.re = 16'(sat16(ar - pr)); eb.im = 16'(sat16(ai - pi));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst_q) begin
        last_a = '0;
        last_b = '0;
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check1("out_valid", out_valid, 1'b1);
        check32("a_out", a_out, e.a);
        check32("b_out", b_out, e.b);
        last_a = e.a;
        last_b = e.b;
      end else begin
        check1("idle_valid", out_valid, 1'b0);
        check32("hold_a_out", a_out, last_a);
        check32("hold_b_out", b_out, last_b);
      end
    end
  end

  task automatic drive_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                           input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = a; b_in = b; w_in = w;
    e.due = cyc + 2; e.a = ea; e.b = eb;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
    cplx_t ea, eb;
    model(a, b, w, ea, eb);
    drive_exp(a, b, w, ea, eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_in = 32'($urandom); b_in = 32'($urandom); w_in = 32'($urandom);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [31:0] tw [9];
  logic [31:0] a_std, b_std;

  initial begin
    tw[0] = {16'sd32767,  16'sd0};
    tw[1] = {16'sd30274, -16'sd12540};
    tw[2] = {16'sd23170, -16'sd23170};
    tw[3] = {16'sd12540, -16'sd30274};
    tw[4] = {16'sd0,     -16'sd32768};
    tw[5] = {-16'sd12540, -16'sd30274};
    tw[6] = {-16'sd23170, -16'sd23170};
    tw[7] = {-16'sd30274, -16'sd12540};
    tw[8] = {-16'sd32768, 16'sd0};
    a_std = {16'sd100, 16'sd0};
    b_std = {16'sd100, 16'sd0};

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check1("reset_valid", out_valid, 1'b0);
    check32("reset_a_out", a_out, 32'h0);
    check32("reset_b_out", b_out, 32'h0);
    rst = 1'b0;
    idle(2);

    // Known twiddles with hand-derived results
    drive_exp(a_std, b_std, 32'h7FFF_0000, 32'h00C8_0000, 32'h0000_0000); idle(3);
    drive_exp(a_std, b_std, 32'h5A82_A57E, 32'h00AB_FFB9, 32'h001D_0047); idle(3);
    drive_exp(a_std, b_std, 32'h0000_8000, 32'h0064_FF9C, 32'h0064_0064); idle(3);
    drive_exp(a_std, b_std, 32'h8000_0000, 32'h0000_0000, 32'h00C8_0000); idle(3);
    drive_exp(32'h7FFF_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h0000_0000);
    idle(3);

    // Full-twiddle stream back to back, then again with a reset mid-stream
    for (int k = 0; k < 9; k++) drive(a_std, b_std, tw[k]);
    idle(3);
    for (int k = 0; k < 5; k++) drive(a_std, b_std, tw[k]);
    pulse_reset();
    for (int k = 5; k < 9; k++) drive(a_std, b_std, tw[k]);
    idle(3);

    // Reset with nothing pending, then immediate first input
    pulse_reset();
    drive(32'h1234_8765, 32'h7FFF_7FFF, 32'h8000_8000);
    for (int k = 0; k < 12; k++) drive(32'($urandom), 32'($urandom), 32'($urandom));
    idle(1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain pending=%0d expected=0", sb.size());
    end
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/butterfly_unit.md
BUTTERFLY_UNIT -- requirements
Module: butterfly_unit

Interface
REQ-001 Parameter DATA_W, default 16: width of each real and imaginary component, two's complement.
REQ-002 Parameter FRAC_W, default 15: fractional bits of the twiddle factor (Q1.15).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port in_valid, input, 1: qualifies a_in, b_in and w_in in the current cycle.
REQ-006 Port a_in, input, 2*DATA_W: operand A, packed {real[31:16], imag[15:0]}.
REQ-007 Port b_in, input, 2*DATA_W: operand B, packed {real, imag}.
REQ-008 Port w_in, input, 2*DATA_W: twiddle W in Q1.15, packed {real, imag}; 0x7FFF = +1.0 (approx.), 0x8000 = -1.0.
REQ-009 Port out_valid, output, 1: qualifies a_out and b_out.
REQ-010 Port a_out, output, 2*DATA_W: A + W*B, packed {real, imag}.
REQ-011 Port b_out, output, 2*DATA_W: A - W*B, packed {real, imag}.

Function
REQ-012 The block SHALL compute one radix-2 decimation-in-time butterfly per accepted input: a_out = A + W*B, b_out = A - W*B.
REQ-013 Complex product: P_re = Br*Wr - Bi*Wi, P_im = Br*Wi + Bi*Wr, each formed exactly in at least 2*DATA_W+1 signed bits.
REQ-014 Scaling: each of P_re and P_im SHALL have 2^(FRAC_W-1) added, then be arithmetically shifted right by FRAC_W (round half up, toward +infinity).
REQ-015 The scaled product SHALL saturate to the DATA_W signed range [-32768, 32767].
REQ-016 The final add and subtract SHALL be done at DATA_W+1 bits and saturate to the DATA_W signed range; no divide-by-2 scaling.
REQ-017 Pipeline: 2-cycle latency; inputs valid in cycle N appear on the outputs with out_valid=1 in cycle N+2.
REQ-018 Stage 1 SHALL register the four partial products plus A; stage 2 SHALL register the rounded, saturated sum and difference.
REQ-019 Throughput: one butterfly per cycle; no backpressure; in_valid may be asserted on consecutive cycles.
REQ-020 out_valid SHALL be in_valid delayed by exactly 2 cycles.
REQ-021 Data registers SHALL hold their values when their valid bit is 0.

Reset
REQ-022 When rst=1 at a clock edge, all pipeline registers SHALL clear: out_valid=0, a_out=0, b_out=0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight butterflies; none appears after rst deasserts.
REQ-024 The first input accepted after reset SHALL appear 2 cycles later with out_valid=1.

Structure
REQ-025 A shared package fft_pkg SHALL hold DATA_W, FRAC_W, a packed complex struct type {real, imag}, and saturation/rounding constants.
REQ-026 The complex multiply, with rounding and saturation, SHALL be a sub-module complex_mult; butterfly_unit instantiates it and performs the add/sub stage.

Verification (A=(100,0), B=(100,0) unless stated; values (real,imag))
REQ-027 W=(0x7FFF,0x0000), 0 degrees -> a_out=(200,0), b_out=(0,0), out_valid 2 cycles after in_valid.
REQ-028 W=(0x5A82,0xA57E), -45 degrees -> a_out=(171,-71), b_out=(29,71).
REQ-029 W=(0x0000,0x8000), -90 degrees -> a_out=(100,-100), b_out=(100,100).
REQ-030 W=(0x8000,0x0000), -180 degrees -> a_out=(0,0), b_out=(200,0).
REQ-031 Saturation: A=(32767,0), B=(0x8000,0), W=(0x8000,0) -> a_out real=32767, b_out real=0, no wrap.
REQ-032 Back-to-back stream of nine twiddles (0 to -180 degrees in -22.5 degree steps), with rst pulsed mid-stream -> results in order, 2-cycle latency, no output for the flushed inputs, out_valid=0 for the 2 cycles after reset.
